sym_fold: RTL and testbench

SYM_FOLD -- requirements
Module: sym_fold

---
 rtl/sym_fold_pkg.sv | 35 +++
 rtl/sym_fold_if.sv | 28 ++
 rtl/sym_fold_buf.sv | 107 ++++++++++
 rtl/sym_fold.sv | 75 +++++++
 tb/tb_sym_fold.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/sym_fold_pkg.sv
// Shared fixed-point helpers for the symmetric-fold front end: word width,
// saturating magnitude and the buffered record type.
package sym_fold_pkg;

  // Widest word the record type can carry; M+N must not exceed this.
  localparam int unsigned MAX_W = 32;

  typedef struct packed {
    logic             sign;
    logic [MAX_W-1:0] x;
    logic [MAX_W-1:0] f;
  } fold_rec_t;

  function automatic int unsigned word_w(input int unsigned m, input int unsigned n);
    return m + n;
  endfunction

  // |x| for a w-bit two's-complement value held in the low bits of x;
  // the most-negative code saturates to the largest positive code.
  function automatic logic [MAX_W-1:0] sat_mag(input logic [MAX_W-1:0] x,
                                               input int unsigned w);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] min_neg;
    mask    = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    min_neg = MAX_W'(1) << (w - 1);
    if ((x & min_neg) == '0) begin
      return x & mask;
    end else if ((x & mask) == min_neg) begin
      return min_neg - MAX_W'(1);
    end else begin
      return (~x + MAX_W'(1)) & mask;
    end
  endfunction

endpackage

// File: rtl/sym_fold_if.sv
// Upstream sample, evaluator issue/return and downstream record channels.
interface sym_fold_if #(
  parameter int unsigned W = 12
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x_in;
  logic         fold_valid;
  logic [W-1:0] fold_x;
  logic         f_valid;
  logic [W-1:0] f_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_f;
  logic [W-1:0] out_x;
  logic         out_sign;
  logic         err;

  modport master (
    output in_valid, x_in, f_valid, f_in, out_ready,
    input  in_ready, fold_valid, fold_x, out_valid, out_f, out_x, out_sign, err
  );

  modport slave (
    input  in_valid, x_in, f_valid, f_in, out_ready,
    output in_ready, fold_valid, fold_x, out_valid, out_f, out_x, out_sign, err
  );
endinterface

// File: rtl/sym_fold_buf.sv
// Circular record buffer: tail allocates, ret fills results in issue order,
// head presents the oldest record. Head outputs are registered from next state.
module sym_fold_buf
  import sym_fold_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  fold_rec_t        push_rec,
  input  logic             ret,
  input  logic [MAX_W-1:0] ret_f,
  input  logic             pop,
  output logic             space,
  output logic             head_valid,
  output fold_rec_t        head_rec,
  output logic             drop_c
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fold_rec_t          mem_q [DEPTH];
  fold_rec_t          mem_n [DEPTH];
  logic [DEPTH-1:0]   present_q, present_n;
  logic [PW-1:0]      tail_q, tail_n;
  logic [PW-1:0]      ret_q, ret_n;
  logic [PW-1:0]      head_q, head_n;
  logic [CW-1:0]      count_q, count_n;
  logic [CW-1:0]      pend_q, pend_n;
  logic               space_q, space_n;
  logic               head_valid_q, head_valid_n;
  fold_rec_t          head_rec_q, head_rec_n;
  logic               ret_ok;
  logic               do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_n        = mem_q;
    present_n    = present_q;
    tail_n       = tail_q;
    ret_n        = ret_q;
    head_n       = head_q;
    ret_ok       = (pend_q != '0);
    drop_c       = ret & ~ret_ok;
    do_pop       = pop & head_valid_q;

    if (push) begin
      mem_n[tail_q]     = push_rec;
      present_n[tail_q] = 1'b0;
      tail_n            = inc(tail_q);
    end
    if (ret && ret_ok) begin
      mem_n[ret_q].f   = ret_f;
      present_n[ret_q] = 1'b1;
      ret_n            = inc(ret_q);
    end
    if (do_pop) begin
      present_n[head_q] = 1'b0;
      head_n            = inc(head_q);
    end

    count_n      = count_q + CW'(push) - CW'(do_pop);
    pend_n       = pend_q + CW'(push) - CW'(ret & ret_ok);
    space_n      = (count_n < CW'(DEPTH));
    head_valid_n = present_n[head_n];
    head_rec_n   = mem_n[head_n];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      present_q    <= '0;
      tail_q       <= '0;
      ret_q        <= '0;
      head_q       <= '0;
      count_q      <= '0;
      pend_q       <= '0;
      space_q      <= 1'b0;
      head_valid_q <= 1'b0;
      head_rec_q   <= '0;
    end else begin
      mem_q        <= mem_n;
      present_q    <= present_n;
      tail_q       <= tail_n;
      ret_q        <= ret_n;
      head_q       <= head_n;
      count_q      <= count_n;
      pend_q       <= pend_n;
      space_q      <= space_n;
      head_valid_q <= head_valid_n;
      head_rec_q   <= head_rec_n;
    end
  end

  assign space      = space_q;
  assign head_valid = head_valid_q;
  assign head_rec   = head_rec_q;

endmodule

// File: rtl/sym_fold.sv
// Folds signed samples to |x| for a half-range evaluator and pairs each
// returned f(|x|) with the original sample and its sign.
module sym_fold
  import sym_fold_pkg::*;
#(
  parameter int unsigned M     = 4,
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  sym_fold_if.slave bus
);

  localparam int unsigned W = word_w(M, N);

  logic         accept_c;
  logic         pop_c;
  logic         drop_c;
  logic         head_valid;
  fold_rec_t    head_rec;
  fold_rec_t    push_rec_c;
  logic         fold_valid_q;
  logic [W-1:0] fold_x_q;
  logic         err_q;

  assign accept_c = bus.in_valid & bus.in_ready;
  assign pop_c    = head_valid & bus.out_ready;

  always_comb begin
    push_rec_c      = '0;
    push_rec_c.sign = bus.x_in[W-1];
    push_rec_c.x    = MAX_W'(bus.x_in);
  end

  sym_fold_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (accept_c),
    .push_rec   (push_rec_c),
    .ret        (bus.f_valid),
    .ret_f      (MAX_W'(bus.f_in)),
    .pop        (pop_c),
    .space      (bus.in_ready),
    .head_valid (head_valid),
    .head_rec   (head_rec),
    .drop_c     (drop_c)
  );

  // Operand issue one cycle after accept; err latches any orphan return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fold_valid_q <= 1'b0;
      fold_x_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      fold_valid_q <= accept_c;
      if (accept_c) begin
        fold_x_q <= W'(sat_mag(MAX_W'(bus.x_in), W));
      end
      err_q <= err_q | drop_c;
    end
  end

  assign bus.fold_valid = fold_valid_q;
  assign bus.fold_x     = fold_x_q;
  assign bus.err        = err_q;
  assign bus.out_valid  = head_valid;
  assign bus.out_f      = W'(head_rec.f);
  assign bus.out_x      = W'(head_rec.x);
  assign bus.out_sign   = head_rec.sign;

endmodule

// File: tb/tb_sym_fold.sv
// Directed bench for sym_fold (M=4, N=8, DEPTH=4) with hand-computed expectations.
module tb_sym_fold;

  localparam int unsigned W = 12;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  sym_fold_if #(.W(W)) bus ();

  sym_fold #(
    .M     (4),
    .N     (8),
    .DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.x_in      = '0;
    bus.f_valid   = 1'b0;
    bus.f_in      = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) cyc();
    check("rst_in_ready",   32'(bus.in_ready),   32'h0);
    check("rst_out_valid",  32'(bus.out_valid),  32'h0);
    check("rst_fold_valid", 32'(bus.fold_valid), 32'h0);
    check("rst_err",        32'(bus.err),        32'h0);
    check("rst_out_x",      32'(bus.out_x),      32'h0);
    #3 rst_n = 1'b1;
    cyc();
    check("post_rst_in_ready", 32'(bus.in_ready), 32'h1);

    // -1.5 folds to +1.5, result paired with original sample
    bus.in_valid = 1'b1; bus.x_in = 12'hE80;
    cyc();
    bus.in_valid = 1'b0;
    check("t1_fold_valid", 32'(bus.fold_valid), 32'h1);
    check("t1_fold_x",     32'(bus.fold_x),     32'h180);
    check("t1_out_valid0", 32'(bus.out_valid),  32'h0);
    bus.f_valid = 1'b1; bus.f_in = 12'h0C0;
    cyc();
    bus.f_valid = 1'b0;
    check("t1_fold_valid_drop", 32'(bus.fold_valid), 32'h0);
    check("t1_out_valid", 32'(bus.out_valid), 32'h1);
    check("t1_out_f",     32'(bus.out_f),     32'h0C0);
    check("t1_out_x",     32'(bus.out_x),     32'hE80);
    check("t1_out_sign",  32'(bus.out_sign),  32'h1);
    cyc();
    check("t1_hold_valid", 32'(bus.out_valid), 32'h1);
    check("t1_hold_f",     32'(bus.out_f),     32'h0C0);
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    check("t1_popped", 32'(bus.out_valid), 32'h0);

    // Most-negative input saturates
    bus.in_valid = 1'b1; bus.x_in = 12'h800;
    cyc();
    bus.in_valid = 1'b0;
    check("t2_fold_x", 32'(bus.fold_x), 32'h7FF);
    bus.f_valid = 1'b1; bus.f_in = 12'h123;
    cyc();
    bus.f_valid = 1'b0;
    check("t2_out_x",    32'(bus.out_x),    32'h800);
    check("t2_out_sign", 32'(bus.out_sign), 32'h1);
    check("t2_out_f",    32'(bus.out_f),    32'h123);
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    check("t2_popped", 32'(bus.out_valid), 32'h0);

    // Fill to DEPTH, fill results, drain one per cycle
    for (int i = 1; i <= 4; i++) begin
      check("t3_ready_before_accept", 32'(bus.in_ready), 32'h1);
      bus.in_valid = 1'b1; bus.x_in = 12'(i);
      cyc();
    end
    bus.in_valid = 1'b0;
    check("t3_full_in_ready", 32'(bus.in_ready), 32'h0);
    for (int i = 1; i <= 4; i++) begin
      bus.f_valid = 1'b1; bus.f_in = 12'(i * 12'h011);
      cyc();
      check("t3_full_hold", 32'(bus.in_ready), 32'h0);
    end
    bus.f_valid = 1'b0;
    check("t3_head_valid", 32'(bus.out_valid), 32'h1);
    check("t3_head_x",     32'(bus.out_x),     32'h001);
    check("t3_head_f",     32'(bus.out_f),     32'h011);
    bus.out_ready = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      cyc();
      check("t3_drain_valid", 32'(bus.out_valid), 32'h1);
      check("t3_drain_x",     32'(bus.out_x),     32'(i));
      check("t3_drain_f",     32'(bus.out_f),     32'(i * 12'h011));
      if (i == 2) check("t3_ready_after_pop", 32'(bus.in_ready), 32'h1);
    end
    cyc();
    bus.out_ready = 1'b0;
    check("t3_empty", 32'(bus.out_valid), 32'h0);

    // Latency-3 evaluator, back-to-back inputs, irregular out_ready
    bus.in_valid = 1'b1; bus.x_in = 12'h100;
    cyc();
    check("t4_fold0", 32'(bus.fold_x), 32'h100);
    bus.x_in = 12'hF00;
    cyc();
    check("t4_fold1", 32'(bus.fold_x), 32'h100);
    bus.x_in = 12'h000;
    cyc();
    bus.in_valid = 1'b0;
    check("t4_fold2_valid", 32'(bus.fold_valid), 32'h1);
    check("t4_fold2",       32'(bus.fold_x),     32'h000);
    bus.f_valid = 1'b1; bus.f_in = 12'h0A0;
    cyc();
    check("t4_r0_valid", 32'(bus.out_valid), 32'h1);
    check("t4_r0_x",     32'(bus.out_x),     32'h100);
    check("t4_r0_f",     32'(bus.out_f),     32'h0A0);
    check("t4_r0_sign",  32'(bus.out_sign),  32'h0);
    bus.f_in = 12'h0B0; bus.out_ready = 1'b1;
    cyc();
    check("t4_r1_x",    32'(bus.out_x),    32'hF00);
    check("t4_r1_f",    32'(bus.out_f),    32'h0B0);
    check("t4_r1_sign", 32'(bus.out_sign), 32'h1);
    bus.f_in = 12'h0C0; bus.out_ready = 1'b0;
    cyc();
    bus.f_valid = 1'b0;
    check("t4_r1_stall_x", 32'(bus.out_x), 32'hF00);
    bus.out_ready = 1'b1;
    cyc();
    check("t4_r2_valid", 32'(bus.out_valid), 32'h1);
    check("t4_r2_x",     32'(bus.out_x),     32'h000);
    check("t4_r2_f",     32'(bus.out_f),     32'h0C0);
    cyc();
    bus.out_ready = 1'b0;
    check("t4_empty", 32'(bus.out_valid), 32'h0);
    check("t4_no_err", 32'(bus.err), 32'h0);

    // Orphan return sets sticky err
    bus.f_valid = 1'b1; bus.f_in = 12'h555;
    cyc();
    bus.f_valid = 1'b0;
    check("t5_err",       32'(bus.err),       32'h1);
    check("t5_out_valid", 32'(bus.out_valid), 32'h0);
    repeat (3) cyc();
    check("t5_err_sticky", 32'(bus.err), 32'h1);

    // Reset with three entries pending
    for (int i = 1; i <= 3; i++) begin
      bus.in_valid = 1'b1; bus.x_in = 12'(i * 16);
      cyc();
    end
    bus.in_valid = 1'b0;
    bus.f_valid = 1'b1; bus.f_in = 12'h055;
    cyc();
    bus.f_valid = 1'b0;
    check("t6_pre_valid", 32'(bus.out_valid), 32'h1);
    check("t6_pre_x",     32'(bus.out_x),     32'h010);
    #2 rst_n = 1'b0;
    #1;
    check("t6_in_ready",  32'(bus.in_ready),  32'h0);
    check("t6_out_valid", 32'(bus.out_valid), 32'h0);
    check("t6_out_x",     32'(bus.out_x),     32'h0);
    check("t6_out_f",     32'(bus.out_f),     32'h0);
    check("t6_out_sign",  32'(bus.out_sign),  32'h0);
    check("t6_fold_x",    32'(bus.fold_x),    32'h0);
    check("t6_err",       32'(bus.err),       32'h0);
    #3 rst_n = 1'b1;
    cyc();
    check("t6_ready_after", 32'(bus.in_ready),  32'h1);
    check("t6_valid_after", 32'(bus.out_valid), 32'h0);
    bus.f_valid = 1'b1; bus.f_in = 12'h077;
    cyc();
    bus.f_valid = 1'b0;
    check("t6_late_return_err", 32'(bus.err),       32'h1);
    check("t6_late_return_out", 32'(bus.out_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
